// File: rtl/bbox_scan_ctrl_pkg.sv
// Shared definitions for the bounding-box raster scan controller:
// FSM state encoding and default screen geometry.
package bbox_scan_ctrl_pkg;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_SKIP = 2'd2
    } state_e;

endpackage

// File: rtl/bbox_scan_ctrl_clip.sv
// Combinational clipper: clamps a signed inclusive box to the screen and
// flags boxes that have no on-screen pixels.
module bbox_clip
    import bbox_scan_ctrl_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int COORD_W  = 12
) (
    input  logic signed [COORD_W-1:0] min_x,
    input  logic signed [COORD_W-1:0] max_x,
    input  logic signed [COORD_W-1:0] min_y,
    input  logic signed [COORD_W-1:0] max_y,
    output logic        [COORD_W-2:0] lo_x,
    output logic        [COORD_W-2:0] hi_x,
    output logic        [COORD_W-2:0] lo_y,
    output logic        [COORD_W-2:0] hi_y,
    output logic                      empty
);

    localparam logic signed [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W - 1);
    localparam logic signed [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H - 1);

    logic signed [COORD_W-1:0] c_min_x, c_max_x, c_min_y, c_max_y;

    always_comb begin
        c_min_x = min_x[COORD_W-1] ? '0 : min_x;
        c_min_y = min_y[COORD_W-1] ? '0 : min_y;
        c_max_x = (max_x > X_LIM) ? X_LIM : max_x;
        c_max_y = (max_y > Y_LIM) ? Y_LIM : max_y;
        // Signed compare also catches boxes wholly left/above or right/below the screen.
        empty   = (c_min_x > c_max_x) || (c_min_y > c_max_y);
        lo_x    = (COORD_W-1)'($unsigned(c_min_x));
        hi_x    = (COORD_W-1)'($unsigned(c_max_x));
        lo_y    = (COORD_W-1)'($unsigned(c_min_y));
        hi_y    = (COORD_W-1)'($unsigned(c_max_y));
    end

endmodule

// File: rtl/bbox_scan_ctrl.sv
// Accepts one bounding box at a time, clips it to the screen and emits its
// pixels in raster order at one pixel per clock under ready/valid flow control.
module bbox_scan_ctrl
    import bbox_scan_ctrl_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int COORD_W  = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      nd,
    output logic                      us_rfd,
    input  logic signed [COORD_W-1:0] min_x,
    input  logic signed [COORD_W-1:0] max_x,
    input  logic signed [COORD_W-1:0] min_y,
    input  logic signed [COORD_W-1:0] max_y,
    input  logic                      ds_rfd,
    output logic                      rdy,
    output logic        [COORD_W-2:0] pix_x,
    output logic        [COORD_W-2:0] pix_y,
    output logic                      pix_first,
    output logic                      pix_last,
    output logic                      skip
);

    localparam int PW = COORD_W - 1;

    state_e        state_q, state_d;
    logic [PW-1:0] x_q, x_d, y_q, y_d;
    logic [PW-1:0] min_x_q, min_x_d, max_x_q, max_x_d, max_y_q, max_y_d;
    logic          first_q, first_d;

    logic [PW-1:0] lo_x, hi_x, lo_y, hi_y;
    logic          empty;
    logic          at_row_end, at_last;

    bbox_clip #(
        .SCREEN_W(SCREEN_W),
        .SCREEN_H(SCREEN_H),
        .COORD_W (COORD_W)
    ) u_clip (
        .min_x(min_x),
        .max_x(max_x),
        .min_y(min_y),
        .max_y(max_y),
        .lo_x (lo_x),
        .hi_x (hi_x),
        .lo_y (lo_y),
        .hi_y (hi_y),
        .empty(empty)
    );

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        min_x_d    = min_x_q;
        max_x_d    = max_x_q;
        max_y_d    = max_y_q;
        first_d    = first_q;
        at_row_end = (x_q == max_x_q);
        at_last    = at_row_end && (y_q == max_y_q);

        case (state_q)
            ST_IDLE: begin
                if (nd) begin
                    if (empty) begin
                        state_d = ST_SKIP;
                    end else begin
                        state_d = ST_SCAN;
                        x_d     = lo_x;
                        y_d     = lo_y;
                        min_x_d = lo_x;
                        max_x_d = hi_x;
                        max_y_d = hi_y;
                        first_d = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                // Counters only advance on a completed transfer, so a stall holds everything.
                if (ds_rfd) begin
                    first_d = 1'b0;
                    if (at_last) begin
                        state_d = ST_IDLE;
                    end else if (at_row_end) begin
                        x_d = min_x_q;
                        y_d = y_q + PW'(1);
                    end else begin
                        x_d = x_q + PW'(1);
                    end
                end
            end
            ST_SKIP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            min_x_q <= '0;
            max_x_q <= '0;
            max_y_q <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            min_x_q <= min_x_d;
            max_x_q <= max_x_d;
            max_y_q <= max_y_d;
            first_q <= first_d;
        end
    end

    assign us_rfd    = (state_q == ST_IDLE);
    assign rdy       = (state_q == ST_SCAN);
    assign skip      = (state_q == ST_SKIP);
    assign pix_x     = x_q;
    assign pix_y     = y_q;
    assign pix_first = rdy && first_q;
    assign pix_last  = rdy && at_last;

endmodule

// File: tb/tb_bbox_scan_ctrl.sv
// Scoreboard bench for bbox_scan_ctrl: directed boxes push expected pixels or
// skip events; a monitor pops and compares on every transfer or skip pulse.
module tb_bbox_scan_ctrl;

    localparam int CW = 12;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 nd;
    logic                 us_rfd;
    logic signed [CW-1:0] min_x, max_x, min_y, max_y;
    logic                 ds_rfd;
    logic                 rdy;
    logic [CW-2:0]        pix_x, pix_y;
    logic                 pix_first, pix_last, skip;

    typedef struct {
        bit is_skip;
        int x;
        int y;
        bit first;
        bit last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   ds_mode = 1'b0;

    always #5 clk = ~clk;

    bbox_scan_ctrl #(
        .SCREEN_W(640),
        .SCREEN_H(480),
        .COORD_W (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst_n),
        .nd       (nd),
        .us_rfd   (us_rfd),
        .min_x    (min_x),
        .max_x    (max_x),
        .min_y    (min_y),
        .max_y    (max_y),
        .ds_rfd   (ds_rfd),
        .rdy      (rdy),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .pix_first(pix_first),
        .pix_last (pix_last),
        .skip     (skip)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_pix(input int x, input int y, input bit f, input bit l);
        exp_t e;
        e.is_skip = 1'b0;
        e.x       = x;
        e.y       = y;
        e.first   = f;
        e.last    = l;
        q.push_back(e);
    endtask

    task automatic push_raster(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                push_pix(x, y, (x == x0) && (y == y0), (x == x1) && (y == y1));
    endtask

    task automatic push_skip();
        exp_t e;
        e.is_skip = 1'b1;
        e.x       = 0;
        e.y       = 0;
        e.first   = 1'b0;
        e.last    = 1'b0;
        q.push_back(e);
    endtask

    task automatic send_box(input int a, input int b, input int c, input int d,
                            input bit empty, input int npix, input bit chk_cyc);
        int n = 0;
        @(posedge clk);
        #1;
        chk("us_rfd_before_box", 32'(us_rfd), 32'd1);
        min_x = CW'(a);
        max_x = CW'(b);
        min_y = CW'(c);
        max_y = CW'(d);
        nd    = 1'b1;
        @(posedge clk);
        #1;
        nd = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("first_cycle_rdy", 32'(rdy), 32'(!empty));
                chk("first_cycle_skip", 32'(skip), 32'(empty));
                chk("busy_us_rfd", 32'(us_rfd), 32'd0);
            end
        end while (us_rfd !== 1'b1 && n < 400);
        if (us_rfd !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL box_timeout: us_rfd=%0b after %0d cycles, required 1", us_rfd, n);
        end else if (chk_cyc) begin
            chk("cycles_to_us_rfd", 32'(n), empty ? 32'd2 : 32'(npix + 1));
        end
        chk("queue_drained", 32'(q.size()), 32'd0);
    endtask

    // ds_rfd source: constant 1, or the repeating 1,0,0 stall pattern.
    initial begin
        int ph = 0;
        ds_rfd = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ds_mode) begin
                ds_rfd = (ph == 0);
                ph     = (ph == 2) ? 0 : ph + 1;
            end else begin
                ds_rfd = 1'b1;
                ph     = 0;
            end
        end
    end

    // Monitor: pops on each pixel transfer or skip pulse, and checks stall stability.
    initial begin
        bit          hold_pend = 1'b0;
        logic [24:0] hold_val  = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend)
                    chk("stall_hold", 32'({rdy, pix_x, pix_y, pix_first, pix_last}), 32'(hold_val));
                if (rdy === 1'b1 && ds_rfd === 1'b1) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pixel: got (%0d,%0d), required none", pix_x, pix_y);
                    end else begin
                        e = q.pop_front();
                        chk("pix_is_skip", 32'(skip), 32'(e.is_skip));
                        chk("pix_x", 32'(pix_x), 32'(e.x));
                        chk("pix_y", 32'(pix_y), 32'(e.y));
                        chk("pix_first", 32'(pix_first), 32'(e.first));
                        chk("pix_last", 32'(pix_last), 32'(e.last));
                    end
                end
                if (skip === 1'b1) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_skip: got skip=1, required 0");
                    end else begin
                        e = q.pop_front();
                        chk("skip_expected", 32'(e.is_skip), 32'd1);
                        chk("skip_rdy", 32'(rdy), 32'd0);
                    end
                end
                hold_pend = (rdy === 1'b1) && (ds_rfd === 1'b0);
                hold_val  = {rdy, pix_x, pix_y, pix_first, pix_last};
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        nd    = 1'b0;
        min_x = '0;
        max_x = '0;
        min_y = '0;
        max_y = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_us_rfd", 32'(us_rfd), 32'd1);
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_skip", 32'(skip), 32'd0);
        chk("rst_pix_first", 32'(pix_first), 32'd0);
        chk("rst_pix_last", 32'(pix_last), 32'd0);
        chk("rst_pix_x", 32'(pix_x), 32'd0);
        chk("rst_pix_y", 32'(pix_y), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        push_raster(2, 4, 3, 4);
        send_box(2, 4, 3, 4, 1'b0, 6, 1'b1);

        push_raster(0, 1, 0, 0);
        send_box(-5, 1, -2, 0, 1'b0, 2, 1'b1);

        push_raster(638, 639, 478, 479);
        send_box(638, 700, 478, 500, 1'b0, 4, 1'b1);

        push_skip();
        send_box(5, 4, 0, 0, 1'b1, 0, 1'b1);

        push_skip();
        send_box(700, 710, 10, 20, 1'b1, 0, 1'b1);

        push_skip();
        send_box(0, 10, -8, -1, 1'b1, 0, 1'b1);

        ds_mode = 1'b1;
        push_raster(0, 2, 0, 1);
        send_box(0, 2, 0, 1, 1'b0, 6, 1'b0);
        ds_mode = 1'b0;

        // Reset after the third pixel of a 4x4 box; the fourth must never appear.
        push_pix(0, 0, 1'b1, 1'b0);
        push_pix(1, 0, 1'b0, 1'b0);
        push_pix(2, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        min_x = CW'(0);
        max_x = CW'(3);
        min_y = CW'(0);
        max_y = CW'(3);
        nd    = 1'b1;
        @(posedge clk);
        #1;
        nd = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rdy", 32'(rdy), 32'd0);
        chk("midrst_us_rfd", 32'(us_rfd), 32'd1);
        chk("midrst_pix_x", 32'(pix_x), 32'd0);
        chk("midrst_pix_y", 32'(pix_y), 32'd0);
        chk("midrst_pix_first", 32'(pix_first), 32'd0);
        chk("midrst_pix_last", 32'(pix_last), 32'd0);
        chk("midrst_pixels_seen", 32'(q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_us_rfd", 32'(us_rfd), 32'd1);
        chk("post_rst_rdy", 32'(rdy), 32'd0);

        push_pix(7, 7, 1'b1, 1'b1);
        send_box(7, 7, 7, 7, 1'b0, 1, 1'b1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bbox_scan_ctrl.md
BBOX_SCAN_CTRL -- requirements
Module: bbox_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SCREEN_W, default 640, meaning horizontal pixel count.
REQ-002 The block SHALL have parameter SCREEN_H, default 480, meaning vertical pixel count.
REQ-003 The block SHALL have parameter COORD_W, default 12, meaning the width of the signed box-coordinate inputs.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port nd, input, 1 bit: a new bounding box is presented.
REQ-007 The block SHALL have port us_rfd, output, 1 bit: ready to accept a box.
REQ-008 The block SHALL have ports min_x, max_x, min_y, max_y, input, COORD_W bits each: signed two's-complement integer pixel bounds, inclusive.
REQ-009 The block SHALL have port ds_rfd, input, 1 bit: downstream ready for a pixel.
REQ-010 The block SHALL have port rdy, output, 1 bit: pix_* holds a valid pixel.
REQ-011 The block SHALL have ports pix_x and pix_y, output, COORD_W-1 bits each: unsigned pixel coordinates.
REQ-012 The block SHALL have port pix_first, output, 1 bit: the current pixel is the first pixel of the box.
REQ-013 The block SHALL have port pix_last, output, 1 bit: the current pixel is the last pixel of the box.
REQ-014 The block SHALL have port skip, output, 1 bit: one-cycle pulse, the accepted box had no on-screen pixels.

Function
REQ-015 A box SHALL be accepted only in a cycle where nd=1 and us_rfd=1.
REQ-016 A pixel SHALL transfer only in a cycle where rdy=1 and ds_rfd=1.
REQ-017 On acceptance, the bounds SHALL be clipped as follows: min values below 0 become 0; max_x above SCREEN_W-1 becomes SCREEN_W-1; max_y above SCREEN_H-1 becomes SCREEN_H-1.
REQ-018 A clipped box with min_x>max_x or min_y>max_y (including fully off-screen) SHALL be treated as empty.
REQ-019 The FSM SHALL have states IDLE, SCAN and SKIP.
REQ-020 In IDLE, us_rfd SHALL be 1 and rdy SHALL be 0.
REQ-021 On acceptance of a non-empty box, the FSM SHALL go IDLE->SCAN, with the first pixel (clipped min_x, min_y) valid on rdy in the next cycle.
REQ-022 On acceptance of an empty box, the FSM SHALL go IDLE->SKIP; skip SHALL be 1 for exactly one cycle; the FSM SHALL then return to IDLE, and no rdy SHALL be asserted for that box.
REQ-023 In SCAN and SKIP, us_rfd SHALL be 0, and nd SHALL be ignored.
REQ-024 Scan order SHALL be raster: x increments from min_x to max_x, then x wraps to min_x and y increments, ending at (max_x, max_y).
REQ-025 While rdy=1 and ds_rfd=0, pix_x, pix_y, pix_first, pix_last and rdy SHALL hold stable.
REQ-026 With ds_rfd held at 1, pixels SHALL be emitted on consecutive cycles with no bubbles.
REQ-027 pix_first SHALL be 1 only with the first pixel, and pix_last SHALL be 1 only with (max_x, max_y); a one-pixel box asserts both.
REQ-028 The transfer of the last pixel SHALL move the FSM SCAN->IDLE, with us_rfd=1 in the following cycle.
REQ-029 Throughput SHALL be one pixel per clock.
REQ-030 Acceptance-to-first-pixel latency SHALL be 1 cycle.
REQ-031 Idle turnaround between boxes SHALL be 1 cycle.
REQ-032 Comparisons SHALL be signed for clipping, and x/y counters SHALL be unsigned COORD_W-1 bits.
REQ-033 Counters SHALL never exceed the clipped max.

Reset
REQ-034 While rst=0, the block SHALL asynchronously force the following values: state=IDLE, us_rfd=1, rdy=0, skip=0, pix_first=0, pix_last=0, pix_x=0, pix_y=0.
REQ-035 Reset asserted mid-SCAN SHALL abandon the box immediately; after release, the block SHALL be in IDLE with no residual pixels.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding and the SCREEN_W/SCREEN_H defaults.
REQ-037 Clipping SHALL be one natural sub-module, bbox_clip: combinational, producing clipped bounds and an empty flag.
REQ-038 The FSM and counters SHALL reside in bbox_scan_ctrl.
REQ-039 The block SHALL sit downstream of bounding_box after float-to-integer conversion.

Verification
REQ-040 Box (2,3)-(4,4) with ds_rfd=1 SHALL emit (2,3),(3,3),(4,3),(2,4),(3,4),(4,4) on 6 consecutive cycles, pix_first on #1 and pix_last on #6, then us_rfd=1.
REQ-041 Box (-5,-2)-(1,0) SHALL emit exactly (0,0),(1,0).
REQ-042 Box (638,478)-(700,500) SHALL emit (638,478),(639,478),(638,479),(639,479).
REQ-043 Box min_x=5, max_x=4, and box min_x=700, max_x=710, SHALL each give a single skip pulse, rdy never 1, and us_rfd=1 two cycles after acceptance.
REQ-044 Box (0,0)-(2,1) with ds_rfd toggling 1,0,0,1,... SHALL emit the same 6-pixel sequence, outputs stable during stalls, and no pixel lost or duplicated.
REQ-045 rst=0 after the 3rd pixel of a 4x4 box SHALL make rdy=0 immediately; after release, us_rfd=1 and a new box (7,7)-(7,7) SHALL emit one pixel with pix_first=pix_last=1.
